rr_grant_sequencer: RTL and testbench

Sequential round-robin grant controller for N requesters. Owns the rotating priority pointer and picks the winning requester. Offers the grant downstream with a valid/ready handshake, then holds ownership until the owner finishes. It sits directly upstream of the grant consumer and turns static priority encoding into fair, stateful arbitration.

---
 rtl/rr_grant_sequencer.sv | 109 ++++++++++
 tb/tb_rr_grant_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant controller: picks a winner starting at the rotating pointer,
// offers it downstream with valid/ready, then holds ownership until released.
module rr_grant_sequencer #(
  parameter int N     = 8,
  parameter int CNT_W = 16,
  parameter int PW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  input  logic             gnt_ready,
  output logic             gnt_valid,
  output logic [PW-1:0]    gnt_id,
  output logic [N-1:0]     gnt_onehot,
  output logic             busy,
  output logic [PW-1:0]    ptr,
  output logic [CNT_W-1:0] grant_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    ptr_n, id_n, winner, idx;
  logic [N-1:0]     onehot_n;
  logic [CNT_W-1:0] cnt_n;
  logic             found;

  // Rotating scan: N is a power of two, so PW-bit addition wraps modulo N for free.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + PW'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    id_n     = gnt_id;
    onehot_n = gnt_onehot;
    cnt_n    = grant_count;
    case (state)
      IDLE: begin
        if (found) begin
          state_n  = OFFER;
          id_n     = winner;
          onehot_n = N'(1) << winner;
        end
      end
      OFFER: begin
        // Acceptance takes priority over a same-cycle withdrawal.
        if (gnt_ready) begin
          state_n = BUSY;
          if (grant_count != '1)
            cnt_n = grant_count + CNT_W'(1);
        end else if (!req[gnt_id]) begin
          state_n  = IDLE;
          id_n     = '0;
          onehot_n = '0;
        end
      end
      BUSY: begin
        if (done || !req[gnt_id]) begin
          state_n  = IDLE;
          ptr_n    = gnt_id + PW'(1);
          id_n     = '0;
          onehot_n = '0;
        end
      end
      default: begin
        state_n  = IDLE;
        id_n     = '0;
        onehot_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      gnt_id      <= '0;
      gnt_onehot  <= '0;
      gnt_valid   <= 1'b0;
      busy        <= 1'b0;
      grant_count <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      gnt_id      <= id_n;
      gnt_onehot  <= onehot_n;
      gnt_valid   <= (state_n == OFFER);
      busy        <= (state_n == BUSY);
      grant_count <= cnt_n;
    end
  end

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Table-driven bench for rr_grant_sequencer; a second instance with a 2-bit
// counter shares the stimulus to exercise count saturation.
module tb_rr_grant_sequencer;

  localparam int N     = 8;
  localparam int PW    = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic             done;
  logic             gnt_ready;
  logic             gnt_valid, busy;
  logic [PW-1:0]    gnt_id, ptr;
  logic [N-1:0]     gnt_onehot;
  logic [CNT_W-1:0] grant_count;
  logic             s_gnt_valid, s_busy;
  logic [PW-1:0]    s_gnt_id, s_ptr;
  logic [N-1:0]     s_gnt_onehot;
  logic [1:0]       s_grant_count;

  rr_grant_sequencer #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt_ready(gnt_ready),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_onehot(gnt_onehot),
    .busy(busy), .ptr(ptr), .grant_count(grant_count)
  );

  rr_grant_sequencer #(.N(N), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done), .gnt_ready(gnt_ready),
    .gnt_valid(s_gnt_valid), .gnt_id(s_gnt_id), .gnt_onehot(s_gnt_onehot),
    .busy(s_busy), .ptr(s_ptr), .grant_count(s_grant_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [7:0]  req;
    logic        rdy;
    logic        done;
    logic        valid;
    logic        busy;
    logic [2:0]  id;
    logic [2:0]  ptr;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_row  = 0;

  task automatic addRow(input logic r, input logic [7:0] rq, input logic rd, input logic dn,
                        input logic v, input logic b, input int id, input int p, input int c);
    vec_t t;
    t.rst_n = r;  t.req = rq;  t.rdy = rd;  t.done = dn;
    t.valid = v;  t.busy = b;  t.id = 3'(id);  t.ptr = 3'(p);  t.cnt = 16'(c);
    vecs.push_back(t);
  endtask

  // One full grant: offered, accepted, then released by done.
  task automatic addGrant(input logic [7:0] rq, input int id, input int p, input int c);
    addRow(1'b1, rq, 1'b1, 1'b0, 1'b1, 1'b0, id, p, c);
    addRow(1'b1, rq, 1'b1, 1'b0, 1'b0, 1'b1, id, p, c + 1);
    addRow(1'b1, rq, 1'b0, 1'b1, 1'b0, 1'b0, 0, (id + 1) % 8, c + 1);
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL row %0d %s: got %0h, expected %0h", cur_row, name, act, expv);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rst_n;
    req       = v.req;
    gnt_ready = v.rdy;
    done      = v.done;
    exp_q.push_back(v);
    @(posedge clk);
  endtask

  task automatic checkOutput();
    vec_t       e;
    logic [7:0] eoh;
    logic [1:0] ecnt2;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL row %0d scoreboard: got empty queue, expected an entry", cur_row);
    end else begin
      e     = exp_q.pop_front();
      eoh   = (e.valid || e.busy) ? (8'd1 << e.id) : 8'd0;
      ecnt2 = (e.cnt > 16'd3) ? 2'd3 : e.cnt[1:0];
      cmp("gnt_valid",   32'(gnt_valid),     32'(e.valid));
      cmp("busy",        32'(busy),          32'(e.busy));
      cmp("gnt_id",      32'(gnt_id),        32'(e.id));
      cmp("gnt_onehot",  32'(gnt_onehot),    32'(eoh));
      cmp("ptr",         32'(ptr),           32'(e.ptr));
      cmp("grant_count", 32'(grant_count),   32'(e.cnt));
      cmp("sat_count",   32'(s_grant_count), 32'(ecnt2));
      cmp("sat_gnt_id",  32'(s_gnt_id),      32'(e.id));
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0; gnt_ready = 1'b0;

    // Reset with activity on every input.
    addRow(1'b0, 8'hFF, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    addRow(1'b0, 8'hFF, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    addRow(1'b1, 8'h00, 1'b1, 1'b1, 0, 0, 0, 0, 0);

    // Fair rotation with wrap from 7 back to 0.
    for (int g = 0; g < 10; g++) addGrant(8'hFF, g % 8, g % 8, g);

    // Walk the pointer to 5, then the scan must wrap past 7 to requester 1.
    addGrant(8'h04, 2, 2, 10);
    addGrant(8'h08, 3, 3, 11);
    addGrant(8'h10, 4, 4, 12);
    addGrant(8'h06, 1, 5, 13);

    // Withdrawal during OFFER; done and other requesters ignored while waiting.
    addRow(1'b1, 8'h08, 1'b0, 1'b0, 1, 0, 3, 2, 14);
    addRow(1'b1, 8'h0C, 1'b0, 1'b1, 1, 0, 3, 2, 14);
    addRow(1'b1, 8'h08, 1'b0, 1'b0, 1, 0, 3, 2, 14);
    addRow(1'b1, 8'h00, 1'b0, 1'b0, 0, 0, 0, 2, 14);

    // Accept and withdraw on the same edge: acceptance wins, then exit on withdrawal.
    addRow(1'b1, 8'h20, 1'b0, 1'b0, 1, 0, 5, 2, 14);
    addRow(1'b1, 8'h00, 1'b1, 1'b0, 0, 1, 5, 2, 15);
    addRow(1'b1, 8'h00, 1'b0, 1'b0, 0, 0, 0, 6, 15);

    // Saturation of the 2-bit counter, then reset mid-BUSY and mid-OFFER.
    addRow(1'b0, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 5; g++) addGrant(8'hFF, g, g, g);
    addRow(1'b1, 8'hFF, 1'b1, 1'b0, 1, 0, 5, 5, 5);
    addRow(1'b1, 8'hFF, 1'b1, 1'b0, 0, 1, 5, 5, 6);
    addRow(1'b0, 8'hFF, 1'b1, 1'b1, 0, 0, 0, 0, 0);
    addRow(1'b1, 8'hFF, 1'b0, 1'b0, 1, 0, 0, 0, 0);
    addRow(1'b0, 8'hFF, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    addRow(1'b1, 8'h00, 1'b0, 1'b0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cur_row = i;
      applyStimulus(vecs[i]);
      checkOutput();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
